// File: rtl/rv_lsu.sv
// rv_lsu: load/store unit between the rv32/rv64 core datapath and the system bus.
//
// Takes one memory request at a time from the core. It computes the effective
// address, checks funct3 legality and alignment, and runs a req/ack bus
// transaction with an optional timeout. It then returns sign- or zero-extended
// load data together with a fault code.
//
// Handshakes:
//   req_valid/req_ready : a request is accepted on a rising edge where
//                         req_valid=1 and req_ready=1. req_ready is high only
//                         in IDLE.
//   bus_req/bus_ack|err : bus_req and all bus_* outputs stay stable from the
//                         first BUS cycle until the edge at which bus_ack or
//                         bus_err is sampled high, or until the timeout expires.
//   rsp_valid           : a one-cycle pulse. The rsp_* fields are registered and
//                         hold their value until the next response.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_*               core request (wr, funct3, base, offset, wrdata, rd)
//   rsp_*               completion (valid, load, rd, data, fault, addr)
//   bus_*               system bus (req, ack, err, wr, addr, be, wdata, rdata)
//   dbg_state           current FSM state (0 IDLE, 1 BUS, 2 RESP)
module rv_lsu #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_base,
    input  logic [11:0]       req_offset,
    input  logic [XLEN-1:0]   req_wrdata,
    input  logic [4:0]        req_rd,
    output logic              rsp_valid,
    output logic              rsp_load,
    output logic [4:0]        rsp_rd,
    output logic [XLEN-1:0]   rsp_data,
    output logic [1:0]        rsp_fault,
    output logic [XLEN-1:0]   rsp_addr,
    output logic              bus_req,
    input  logic              bus_ack,
    input  logic              bus_err,
    output logic              bus_wr,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN/8-1:0] bus_be,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic [XLEN-1:0]   bus_rdata,
    output logic [1:0]        dbg_state
);

    localparam int NB = XLEN / 8;
    localparam int LB = $clog2(NB);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] F_NONE  = 2'd0;
    localparam logic [1:0] F_ALIGN = 2'd1;
    localparam logic [1:0] F_ACC   = 2'd2;
    localparam logic [1:0] F_ILL   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_wr;
    logic [2:0]      r_funct3;
    logic [LB-1:0]   r_lane;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_ea;
    logic [TW-1:0]   r_wait;

    logic [XLEN-1:0] w_ea;
    logic [LB-1:0]   w_lane;
    logic            w_legal;
    logic            w_misalign;
    logic [7:0]      w_ones;
    logic [7:0]      w_be8;
    logic [XLEN-1:0] w_rshift;
    logic [XLEN-1:0] w_ext;
    logic            w_timeout;
    logic            w_done;
    logic            w_ok;

    assign dbg_state = r_state;

    // Effective address wraps modulo 2^XLEN.
    assign w_ea   = req_base + {{(XLEN-12){req_offset[11]}}, req_offset};
    assign w_lane = w_ea[LB-1:0];

    always_comb begin
        w_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b011:                 w_legal = (XLEN == 64);
            3'b100, 3'b101:         w_legal = !req_wr;
            3'b110:                 w_legal = !req_wr && (XLEN == 64);
            default:                w_legal = 1'b0;
        endcase
    end

    // funct3[1:0] encodes log2 of the access size for every legal access.
    always_comb begin
        w_misalign = 1'b0;
        w_ones     = 8'h00;
        case (req_funct3[1:0])
            2'd0: begin w_misalign = 1'b0;        w_ones = 8'h01; end
            2'd1: begin w_misalign = w_ea[0];     w_ones = 8'h03; end
            2'd2: begin w_misalign = |w_ea[1:0];  w_ones = 8'h0F; end
            default: begin w_misalign = |w_ea[2:0]; w_ones = 8'hFF; end
        endcase
    end

    // An aligned access never spills past the top lane, so the low NB bits suffice.
    assign w_be8 = w_ones << w_lane;

    // Load data: bring the addressed lane down to bit 0, then extend.
    assign w_rshift = bus_rdata >> {r_lane, 3'b000};

    always_comb begin
        w_ext = w_rshift;
        case (r_funct3)
            3'b000:  w_ext = XLEN'($signed(w_rshift[7:0]));
            3'b001:  w_ext = XLEN'($signed(w_rshift[15:0]));
            3'b010:  w_ext = XLEN'($signed(w_rshift[31:0]));
            3'b100:  w_ext = XLEN'(w_rshift[7:0]);
            3'b101:  w_ext = XLEN'(w_rshift[15:0]);
            3'b110:  w_ext = XLEN'(w_rshift[31:0]);
            default: w_ext = w_rshift;
        endcase
    end

    // r_wait counts completed BUS cycles, so the last allowed cycle sees TIMEOUT-1.
    assign w_timeout = (TIMEOUT != 0) && (r_wait == TW'(TIMEOUT - 1));
    // bus_err wins over bus_ack; a timeout only counts when neither is present.
    assign w_ok      = bus_ack && !bus_err;
    assign w_done    = bus_ack || bus_err || w_timeout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_wr      <= 1'b0;
            r_funct3  <= 3'b000;
            r_lane    <= '0;
            r_rd      <= 5'd0;
            r_ea      <= '0;
            r_wait    <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_load  <= 1'b0;
            rsp_rd    <= 5'd0;
            rsp_data  <= '0;
            rsp_fault <= F_NONE;
            rsp_addr  <= '0;
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_wr      <= req_wr;
                        r_funct3  <= req_funct3;
                        r_lane    <= w_lane;
                        r_rd      <= req_rd;
                        r_ea      <= w_ea;
                        r_wait    <= '0;
                        req_ready <= 1'b0;
                        if (!w_legal || w_misalign) begin
                            // Rejected before touching the bus.
                            r_state   <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_load  <= !req_wr;
                            rsp_rd    <= req_rd;
                            rsp_data  <= '0;
                            rsp_fault <= !w_legal ? F_ILL : F_ALIGN;
                            rsp_addr  <= w_ea;
                        end else begin
                            r_state   <= S_BUS;
                            bus_req   <= 1'b1;
                            bus_wr    <= req_wr;
                            bus_addr  <= {w_ea[XLEN-1:LB], {LB{1'b0}}};
                            bus_be    <= w_be8[NB-1:0];
                            bus_wdata <= req_wrdata << {w_lane, 3'b000};
                        end
                    end
                end
                S_BUS: begin
                    if (w_done) begin
                        r_state   <= S_RESP;
                        bus_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_load  <= !r_wr;
                        rsp_rd    <= r_rd;
                        rsp_addr  <= r_ea;
                        rsp_fault <= w_ok ? F_NONE : F_ACC;
                        rsp_data  <= (w_ok && !r_wr) ? w_ext : '0;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_RESP: begin
                    r_state   <= S_IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    r_state   <= S_IDLE;
                    bus_req   <= 1'b0;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
